// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: default widths, the
// hardwired zero register and the fixed requester slot assignment.
package regfile_write_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT    = 4;
  localparam int DATA_WIDTH_DEFAULT = 16;
  localparam int ADDR_WIDTH_DEFAULT = 3;

  localparam int ZERO_REG = 0;

  localparam int REQ_ALU   = 0;
  localparam int REQ_MEM   = 1;
  localparam int REQ_LINK  = 2;
  localparam int REQ_SPARE = 3;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational rotate-priority picker: returns the first eligible index at or
// after ptr, wrapping to index 0, as a one-hot vector.
module regfile_write_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic             valid
);

  logic found;

  // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i] && (PTR_W'(i) >= ptr)) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig[i]) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = found;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between the
// writeback sources; one registered write per cycle, frozen by hazard hold.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  // Handshake: req[i] is a level request whose addr/data slice must stay stable
  // until gnt[i] pulses; the transfer happens on that edge, and req[i] falls the
  // next cycle. gnt_q masks the just-granted requester so its trailing req is
  // never taken as a second request. Dropping req before gnt withdraws it.
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    win_oh;
  logic                  win_valid;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      rr_ptr_next;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign eligible = req & ~gnt_q;
  assign busy     = |eligible;

  regfile_write_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .elig   (eligible),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        win_idx  = PTR_W'(i);
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    rr_ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else if (win_valid && !hold) begin
      gnt_q   <= win_oh;
      wr_addr <= sel_addr;
      wr_data <= sel_data;
      // Writes to the hardwired zero register are granted but never committed.
      wr_en   <= !(ZERO_DISCARD && (sel_addr == ZERO_ADDR));
      rr_ptr  <= rr_ptr_next;
    end else begin
      gnt_q <= '0;
      wr_en <= 1'b0;
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter: directed scenarios followed by
// requester agents that obey the req/gnt protocol, checked against a queue model.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int RW = N + 1 + AW + DW;
  localparam bit ZD = 1'b1;

  logic            clk;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;

  regfile_write_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file fed by the DUT write port
  logic [DW-1:0] rf [8];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  // stimulus state
  logic [AW-1:0] addr_a [N];
  logic [DW-1:0] data_a [N];
  logic          busy_seen;

  // reference model
  int            m_ptr;
  logic [N-1:0]  m_gnt;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rf_exp [8];
  logic [RW-1:0] exp_q [$];

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_gnt  = '0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One cycle: drive inputs, check busy, predict the post-edge outputs, compare.
  task automatic step(input logic rst, input logic hld, input logic [N-1:0] rq);
    logic [N-1:0]  elig;
    logic [RW-1:0] rec;
    int            w;
    int            idx;
    reset = rst;
    hold  = hld;
    req   = rq;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = addr_a[i];
      req_data[i*DW +: DW] = data_a[i];
    end
    @(negedge clk);
    busy_seen = busy;
    check("busy", 32'(busy), 32'(|(rq & ~m_gnt)));
    if (rst) begin
      model_reset();
    end else begin
      elig = rq & ~m_gnt;
      w = -1;
      if (!hld) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (w < 0 && elig[idx[1:0]]) w = idx;
        end
      end
      if (w >= 0) begin
        m_gnt  = N'(1 << w);
        m_addr = addr_a[w];
        m_data = data_a[w];
        m_wen  = !(ZD && m_addr == AW'(ZERO_REG));
        m_ptr  = (w + 1) % N;
      end else begin
        m_gnt = '0;
        m_wen = 1'b0;
      end
    end
    exp_q.push_back({m_gnt, m_wen, m_addr, m_data});
    @(posedge clk);
    #1;
    rec = exp_q.pop_front();
    check("gnt",     32'(gnt),     32'(rec[RW-1 -: N]));
    check("wr_en",   32'(wr_en),   32'(rec[AW+DW]));
    check("wr_addr", 32'(wr_addr), 32'(rec[DW +: AW]));
    check("wr_data", 32'(wr_data), 32'(rec[DW-1:0]));
    if (rec[AW+DW]) rf_exp[rec[DW +: AW]] = rec[DW-1:0];
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_a[i] = a;
    data_a[i] = d;
  endtask

  logic [N-1:0] active;
  logic [N-1:0] seq3 [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 8; i++) begin
      rf[i]     = '0;
      rf_exp[i] = '0;
    end
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 4), DW'(16'h1000 * (i + 1)));
    reset = 1'b1;
    hold  = 1'b0;
    req   = '0;
    req_addr = '0;
    req_data = '0;
    @(posedge clk);
    #1;
    model_reset();

    // reset held with all requests pending, then full rotation with wrap
    step(1'b1, 1'b0, 4'b1111);
    check("rst_gnt", 32'(gnt), 32'h0);
    step(1'b1, 1'b0, 4'b1111);
    check("rst_wen", 32'(wr_en), 32'h0);
    seq3[0] = 4'b0001; seq3[1] = 4'b0010; seq3[2] = 4'b0100;
    seq3[3] = 4'b1000; seq3[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'b1111);
      check("rr_seq", 32'(gnt), 32'(seq3[i]));
    end
    step(1'b0, 1'b0, 4'b0000);

    // single requester; its trailing req is masked
    set_req(REQ_MEM, 3'd3, 16'h8888);
    step(1'b0, 1'b0, 4'b0010);
    check("single_gnt",  32'(gnt),     32'h2);
    check("single_addr", 32'(wr_addr), 32'h3);
    check("single_data", 32'(wr_data), 32'h8888);
    step(1'b0, 1'b0, 4'b0010);
    check("no_double", 32'(gnt), 32'h0);
    step(1'b0, 1'b0, 4'b0000);

    // write to the zero register is granted but discarded
    set_req(REQ_ALU, 3'd0, 16'hFFFF);
    step(1'b0, 1'b0, 4'b0001);
    check("zero_gnt", 32'(gnt),   32'h1);
    check("zero_wen", 32'(wr_en), 32'h0);
    step(1'b0, 1'b0, 4'b0000);

    // hold freezes grants; release resumes in round-robin order
    set_req(REQ_ALU, 3'd1, 16'h0A0A);
    set_req(REQ_LINK, 3'd2, 16'h0C0C);
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'b0101);
      check("hold_gnt",  32'(gnt),       32'h0);
      check("hold_busy", 32'(busy_seen), 32'h1);
    end
    step(1'b0, 1'b0, 4'b0101);
    check("rel_gnt0", 32'(gnt), 32'h1);
    step(1'b0, 1'b0, 4'b0100);
    check("rel_gnt2", 32'(gnt), 32'h4);

    // reset right after gnt[2]; req[3] still pending afterwards
    set_req(REQ_SPARE, 3'd7, 16'h7777);
    step(1'b1, 1'b0, 4'b1000);
    check("rst_after_wen", 32'(wr_en), 32'h0);
    step(1'b0, 1'b0, 4'b1000);
    check("post_rst_gnt3", 32'(gnt), 32'h8);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b1111);
    check("post_rst_ptr", 32'(gnt), 32'h1);
    step(1'b0, 1'b0, 4'b0000);

    // randomized requester agents
    active = '0;
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), active);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          active[i] = 1'b0;
        end else if (active[i]) begin
          if ($urandom_range(0, 15) == 0) active[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          active[i] = 1'b1;
          set_req(i, AW'($urandom_range(0, 7)), DW'($urandom));
        end
      end
    end
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < 8; i++) check("regfile", 32'(rf[i]), 32'(rf_exp[i]));
    check("reg0_zero", 32'(rf[0]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
